// File: rtl/neuron_mac.sv
// neuron_mac: serial multiply-accumulate neuron core feeding the ReLU stage.
// Accepts N_INPUTS signed x/w pairs and adds a signed bias. The result is
// reduced to 17 bits and presented as an 18-bit value under valid/ready.
// Optional feature macro: NEURON_MAC_SAT_EN. When defined, out-of-range
// sums are clipped and flagged on out_sat. When undefined, sums wrap
// modulo 2^17 and out_sat is always 0.
//
// Handshake: a pair transfers on a rising edge where in_valid && in_ready.
// A result transfers on a rising edge where out_valid && out_ready.
// Both in_ready and out_valid decode the registered state only.
module neuron_mac #(
    parameter int N_INPUTS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  x,
    input  logic [7:0]  w,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [16:0] bias,
    input  logic        flush,
    output logic [17:0] out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sat
);

    localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int AW = 18 + $clog2(N_INPUTS);

    typedef enum logic [1:0] {
        S_ACC  = 2'd0,
        S_DONE = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               state;
    logic signed [AW-1:0] acc;
    logic [CW-1:0]        cnt;
    logic signed [15:0]   prod;
    logic signed [AW-1:0] prod_ext;
    logic [17:0]          sum_out;
    logic                 sum_sat;

    // Full signed 8x8 product always fits in 16 bits.
    assign prod     = $signed(x) * $signed(w);
    assign prod_ext = {{(AW-16){prod[15]}}, prod};

    assign in_ready  = (state == S_ACC);
    assign out_valid = (state == S_HOLD);

`ifdef NEURON_MAC_SAT_EN
    localparam logic signed [AW:0] SAT_HI = (AW+1)'(65535);
    localparam logic signed [AW:0] SAT_LO = (AW+1)'(-65536);

    logic signed [AW:0] sum;
    assign sum = {acc[AW-1], acc} + {{(AW-16){bias[16]}}, bias};

    // Clip the full-width sum to the 17-bit signed range and flag it.
    always_comb begin
        sum_out = sum[17:0];
        sum_sat = 1'b0;
        if (sum > SAT_HI) begin
            sum_out = 18'h0FFFF;
            sum_sat = 1'b1;
        end else if (sum < SAT_LO) begin
            sum_out = 18'h30000;
            sum_sat = 1'b1;
        end
    end
`else
    logic [16:0] sum_w;
    assign sum_w = acc[16:0] + bias;

    // Wrap modulo 2^17: only the low 17 bits of acc can reach the result.
    always_comb begin
        sum_out = {sum_w[16], sum_w};
        sum_sat = 1'b0;
    end
`endif

    // Control FSM plus accumulator, counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_ACC;
            acc     <= '0;
            cnt     <= '0;
            out     <= '0;
            out_sat <= 1'b0;
        end else if (flush) begin
            // Abort the vector; the previously held result value stays on out.
            state <= S_ACC;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_ACC: begin
                    if (in_valid) begin
                        acc <= acc + prod_ext;
                        if (cnt == CW'(N_INPUTS - 1)) begin
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    out     <= sum_out;
                    out_sat <= sum_sat;
                    state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_ACC;
                    end
                end
                default: state <= S_ACC;
            endcase
        end
    end

endmodule
